johnson_phase_sequencer: RTL and testbench
==========================================

Name: johnson_phase_sequencer

Overview:
- Controller that sequences a Johnson counter of configurable width through a programmed number of full revolutions, then stops cleanly.
- Runs the internal Johnson register and decodes each step to a one-hot phase strobe.
- Provides a start/stop/abort control interface and reports progress.
- Sits between a host control FSM and multi-phase timing logic that consumes Phase and Count_out.

Parameters:
- WIDTH, 4, Johnson register width; one revolution = 2*WIDTH states.
- CNT_W, 8, width of the revolution request and revolution-progress counters.

Ports:
- Clock, in, 1, rising-edge clock.
- Reset, in, 1, synchronous active-low reset; all state is cleared on any rising Clock edge where Reset=0.
- Start, in, 1, begin a run; accepted only in IDLE.
- Stop, in, 1, graceful stop: finish the current revolution, then end.
- Abort, in, 1, immediate stop; highest priority after Reset.
- Dir, in, 1, sampled on the Start edge. 0 = left shift, next = {Count_out[WIDTH-2:0], ~Count_out[WIDTH-1]}. 1 = right shift, next = {~Count_out[0], Count_out[WIDTH-1:1]}.
- Revs, in, CNT_W, sampled on the Start edge; number of revolutions to run; 0 = run until Stop or Abort.
- Count_out, out, WIDTH, Johnson register value.
- Phase, out, 2*WIDTH, one-hot step index within the current revolution; all zero unless in RUN or STOP_PEND.
- Wrap, out, 1, one-cycle pulse in the cycle Count_out returns to 0 after completing a revolution.
- Busy, out, 1, high in RUN and STOP_PEND.
- Done, out, 1, one-cycle completion pulse.
- Rev_done, out, CNT_W, revolutions completed in the current or last run; saturates at all-ones.

Behaviour:
- Reset (Reset=0 at an edge): state IDLE; all outputs 0; latched Dir and Revs cleared to 0.
- States: IDLE, RUN, STOP_PEND, DONE. All outputs are registered.
- IDLE:
  - Count_out=0, Phase=0, Busy=0, Wrap=0.
  - Start=1 → RUN. On that edge: latch Dir and Revs, clear Rev_done, set step=0, hold Count_out=0.
- Step indexing:
  - In the first RUN cycle, Count_out=0 and Phase[0]=1.
  - Each subsequent edge in RUN or STOP_PEND shifts Count_out per Dir and advances step by 1.
  - Phase[step]=1.
  - When step=2*WIDTH-1, the next edge sets step=0 and Count_out=0.
- Wrap edge (step 2*WIDTH-1 → 0):
  - Wrap=1 for the following cycle.
  - Rev_done increments, saturating.
  - If latched Revs≠0 and the new Rev_done equals Revs → DONE.
  - If in STOP_PEND → DONE.
  - Otherwise remain in RUN.
- Stop=1 in RUN on a non-wrap edge → STOP_PEND; counting continues unchanged.
- Stop=1 in RUN coinciding with the wrap edge → DONE directly.
- Stop=1 in IDLE, STOP_PEND or DONE → no effect.
- DONE:
  - Lasts exactly one cycle: Done=1, Busy=0, Phase=0, Count_out=0; Wrap=1 is also visible that cycle.
  - Next edge → IDLE unconditionally.
  - Start during DONE is ignored.
- Abort=1 in any non-IDLE state:
  - Next edge → IDLE; Count_out=0, Phase=0, Wrap=0.
  - No Done pulse; Rev_done keeps its value.
  - Abort wins over simultaneous Stop and over a wrap or DONE transition.
  - Abort=1 in IDLE has no effect; Start with Abort in the same cycle is ignored.
- Start asserted while Busy → ignored.
- Dir and Revs changes after the Start edge have no effect until the next accepted Start.
- Latency: Start sampled at edge 0 with Revs=R≥1 → Busy from edge 0; Done pulse follows edge 2*WIDTH*R; Busy=1 for exactly 2*WIDTH*R cycles.
- Invariant: Count_out is always a legal Johnson code; Phase is one-hot whenever Busy=1.

Test Plan:
- Reset=0 for 3 cycles with Start=1 → all outputs 0; state stays IDLE.
- WIDTH=4, Dir=0, Revs=1, Start pulse → Count_out 0000,0001,0011,0111,1111,1110,1100,1000; Phase 0x01…0x80; Busy=1 for 8 cycles; next cycle Done=1, Wrap=1, Rev_done=1, Count_out=0000.
- Dir=1, Revs=2 → Count_out 0000,1000,1100,1110,1111,0111,0011,0001, repeated twice; Wrap pulses twice; Done after 16 Busy cycles; Rev_done=2.
- Revs=0, Stop pulsed at step 3 of revolution 2 → counting continues to the end of revolution 2; Done=1; Rev_done=2; total Busy = 16 cycles.
- Abort at step 5 of revolution 1 (Revs=3) → next cycle IDLE, Count_out=0, Done never pulses, Rev_done=0; Start in the following cycle is accepted normally.
- Start re-pulsed while Busy and during DONE, plus Stop coinciding with the wrap edge → Start ignored both times; immediate DONE with no extra revolution.

Source files
------------

// File: rtl/johnson_phase_sequencer.sv
// -----------------------------------------------------------------------------
// johnson_phase_sequencer
//
// Purpose:
//   Steps a WIDTH-bit Johnson counter through a programmed number of full
//   revolutions (2*WIDTH states each), decodes each step to a one-hot phase
//   strobe and stops cleanly. A host drives Start/Stop/Abort; downstream
//   multi-phase timing logic consumes Phase and Count_out.
//
// Ports:
//   Clock      in   1        rising-edge clock
//   Reset      in   1        synchronous active-low reset
//   Start      in   1        begin a run (accepted only in IDLE, and not
//                            together with Abort)
//   Stop       in   1        graceful stop: finish the current revolution
//   Abort      in   1        immediate stop, no Done pulse
//   Dir        in   1        shift direction, sampled on the Start edge
//                            (0 = left, 1 = right)
//   Revs       in   CNT_W    revolutions to run, sampled on the Start edge;
//                            0 = run until Stop or Abort
//   Count_out  out  WIDTH    Johnson register value
//   Phase      out  2*WIDTH  one-hot step index (zero outside RUN/STOP_PEND)
//   Wrap       out  1        one-cycle pulse when a revolution completes
//   Busy       out  1        high in RUN and STOP_PEND
//   Done       out  1        one-cycle completion pulse
//   Rev_done   out  CNT_W    revolutions completed, saturating
//   fsm_state  out  2        debug view of the controller state
//                            (0 IDLE, 1 RUN, 2 STOP_PEND, 3 DONE)
//
// Control interface:
//   Start is a level sampled on a rising edge; it is taken only when the
//   controller is in IDLE and Abort is low on that same edge, otherwise it is
//   dropped (no queuing). Stop and Abort are likewise sampled per edge and
//   need only be held for one cycle. Every output is registered.
// -----------------------------------------------------------------------------
module johnson_phase_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 Abort,
    input  logic                 Dir,
    input  logic [CNT_W-1:0]     Revs,
    output logic [WIDTH-1:0]     Count_out,
    output logic [2*WIDTH-1:0]   Phase,
    output logic                 Wrap,
    output logic                 Busy,
    output logic                 Done,
    output logic [CNT_W-1:0]     Rev_done,
    output logic [1:0]           fsm_state
);

    localparam int STEPS  = 2 * WIDTH;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(STEPS - 1);
    localparam logic [STEPS-1:0]  PHASE_FIRST = {{(STEPS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t              state;
    logic                dir_q;
    logic [CNT_W-1:0]    revs_q;
    logic [STEP_W-1:0]   step;

    // Next-cycle helper values, derived from the current registered state.
    logic [WIDTH-1:0]    count_next;
    logic [CNT_W-1:0]    rev_inc;
    logic                at_wrap;
    logic                run_complete;

    always_comb begin
        count_next = Count_out;
        if (dir_q) begin
            count_next = {~Count_out[0], Count_out[WIDTH-1:1]};
        end else begin
            count_next = {Count_out[WIDTH-2:0], ~Count_out[WIDTH-1]};
        end
    end

    always_comb begin
        rev_inc = Rev_done;
        if (!(&Rev_done)) begin
            rev_inc = Rev_done + CNT_W'(1);
        end
    end

    // The wrap edge is the one that leaves the last step of a revolution.
    // A run ends on that edge if the programmed count is reached, a stop was
    // already pending, or Stop arrives exactly on the wrap edge.
    always_comb begin
        at_wrap      = (step == LAST_STEP);
        run_complete = ((revs_q != '0) && (rev_inc == revs_q)) ||
                       (state == STOP_PEND) || Stop;
    end

    assign fsm_state = state;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            revs_q    <= '0;
            step      <= '0;
            Count_out <= '0;
            Phase     <= '0;
            Wrap      <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Rev_done  <= '0;
        end else begin
            // Pulses default low; each state re-asserts what it needs.
            Wrap <= 1'b0;
            Done <= 1'b0;

            case (state)
                IDLE: begin
                    Count_out <= '0;
                    Phase     <= '0;
                    Busy      <= 1'b0;
                    step      <= '0;
                    if (Start && !Abort) begin
                        state     <= RUN;
                        dir_q     <= Dir;
                        revs_q    <= Revs;
                        Rev_done  <= '0;
                        Phase     <= PHASE_FIRST;
                        Busy      <= 1'b1;
                    end
                end

                RUN, STOP_PEND: begin
                    if (Abort) begin
                        // Rev_done deliberately keeps its value here.
                        state     <= IDLE;
                        step      <= '0;
                        Count_out <= '0;
                        Phase     <= '0;
                        Busy      <= 1'b0;
                    end else if (at_wrap) begin
                        Wrap      <= 1'b1;
                        Rev_done  <= rev_inc;
                        step      <= '0;
                        Count_out <= '0;
                        if (run_complete) begin
                            state <= DONE;
                            Done  <= 1'b1;
                            Busy  <= 1'b0;
                            Phase <= '0;
                        end else begin
                            state <= RUN;
                            Phase <= PHASE_FIRST;
                        end
                    end else begin
                        step      <= step + STEP_W'(1);
                        Count_out <= count_next;
                        Phase     <= Phase << 1;
                        if ((state == RUN) && Stop) begin
                            state <= STOP_PEND;
                        end
                    end
                end

                DONE: begin
                    // One-cycle completion state; Start and Stop are ignored
                    // and Abort leads to the same place.
                    state     <= IDLE;
                    step      <= '0;
                    Count_out <= '0;
                    Phase     <= '0;
                    Busy      <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    step      <= '0;
                    Count_out <= '0;
                    Phase     <= '0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
module tb_johnson_phase_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic              Clock;
    logic              Reset;
    logic              Start;
    logic              Stop;
    logic              Abort;
    logic              Dir;
    logic [CNT_W-1:0]  Revs;
    logic [WIDTH-1:0]  Count_out;
    logic [2*WIDTH-1:0] Phase;
    logic              Wrap;
    logic              Busy;
    logic              Done;
    logic [CNT_W-1:0]  Rev_done;
    logic [1:0]        fsm_state;

    int vectors;
    int miscompares;

    // Hand-written Johnson sequences for WIDTH=4.
    logic [3:0] seq_left  [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [3:0] seq_right [8] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    johnson_phase_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Stop      (Stop),
        .Abort     (Abort),
        .Dir       (Dir),
        .Revs      (Revs),
        .Count_out (Count_out),
        .Phase     (Phase),
        .Wrap      (Wrap),
        .Busy      (Busy),
        .Done      (Done),
        .Rev_done  (Rev_done),
        .fsm_state (fsm_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one edge and settle; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] cnt, input logic [7:0] ph,
                           input logic wr, input logic bz, input logic dn,
                           input logic [7:0] rd, input logic [1:0] st);
        chk({tag, ".count"},    32'(Count_out), 32'(cnt));
        chk({tag, ".phase"},    32'(Phase),     32'(ph));
        chk({tag, ".wrap"},     32'(Wrap),      32'(wr));
        chk({tag, ".busy"},     32'(Busy),      32'(bz));
        chk({tag, ".done"},     32'(Done),      32'(dn));
        chk({tag, ".rev_done"}, 32'(Rev_done),  32'(rd));
        chk({tag, ".state"},    32'(fsm_state), 32'(st));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset = 1'b0;
        Start = 1'b1;
        Stop  = 1'b0;
        Abort = 1'b0;
        Dir   = 1'b0;
        Revs  = 8'd0;

        // ---- Reset held for 3 cycles with Start high ----
        tick(); tick(); tick();
        chk_all("reset", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, S_IDLE);
        Reset = 1'b1;
        Start = 1'b0;
        tick();
        chk_all("post_reset", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, S_IDLE);

        // ---- Abort together with Start in IDLE: Start ignored ----
        Start = 1'b1; Abort = 1'b1; Revs = 8'd1;
        tick();
        Start = 1'b0; Abort = 1'b0;
        chk_all("start_abort_idle", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, S_IDLE);

        // ---- Dir=0, Revs=1 ----
        Dir = 1'b0; Revs = 8'd1; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_all($sformatf("l1_s%0d", i), seq_left[i], 8'h01 << i, 1'b0, 1'b1, 1'b0, 8'd0, S_RUN);
            tick();
        end
        chk_all("l1_done", 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1, S_DONE);
        tick();
        chk_all("l1_idle", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, S_IDLE);

        // ---- Dir=1, Revs=2; inputs changed after Start must not matter ----
        Dir = 1'b1; Revs = 8'd2; Start = 1'b1;
        tick();
        Start = 1'b0; Dir = 1'b0; Revs = 8'd1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                chk_all($sformatf("r2_r%0d_s%0d", r, i), seq_right[i], 8'h01 << i,
                        (r == 1 && i == 0), 1'b1, 1'b0, 8'(r), S_RUN);
                tick();
            end
        end
        chk_all("r2_done", 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd2, S_DONE);
        tick();
        chk_all("r2_idle", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2, S_IDLE);

        // ---- Revs=0, Stop pulsed at step 3 of revolution 2 ----
        Dir = 1'b0; Revs = 8'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                chk_all($sformatf("stop_r%0d_s%0d", r, i), seq_left[i], 8'h01 << i,
                        (r == 1 && i == 0), 1'b1, 1'b0, 8'(r),
                        (r == 1 && i > 3) ? S_STOP : S_RUN);
                if (r == 1 && i == 3) Stop = 1'b1;
                if (r == 1 && i == 5) Stop = 1'b1;  // repeated Stop in STOP_PEND
                tick();
                Stop = 1'b0;
            end
        end
        chk_all("stop_done", 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd2, S_DONE);
        tick();
        chk_all("stop_idle", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2, S_IDLE);

        // ---- Revs=3, Abort at step 5 of revolution 1 ----
        Dir = 1'b0; Revs = 8'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_all($sformatf("abort_s%0d", i), seq_left[i], 8'h01 << i, 1'b0, 1'b1, 1'b0, 8'd0, S_RUN);
            if (i == 5) begin
                Abort = 1'b1;
                Stop  = 1'b1;
            end
            tick();
        end
        Abort = 1'b0;
        Stop  = 1'b0;
        chk_all("abort_idle", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, S_IDLE);
        Revs = 8'd1; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_all($sformatf("restart_s%0d", i), seq_left[i], 8'h01 << i, 1'b0, 1'b1, 1'b0, 8'd0, S_RUN);
            tick();
        end
        chk_all("restart_done", 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1, S_DONE);
        tick();

        // ---- Start while Busy, Stop on the wrap edge, Start during DONE ----
        Dir = 1'b0; Revs = 8'd2; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_all($sformatf("ign_s%0d", i), seq_left[i], 8'h01 << i, 1'b0, 1'b1, 1'b0, 8'd0, S_RUN);
            if (i == 3) Start = 1'b1;
            if (i == 7) Stop  = 1'b1;
            tick();
            Start = 1'b0;
            Stop  = 1'b0;
        end
        chk_all("ign_done", 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1, S_DONE);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk_all("ign_idle", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, S_IDLE);
        tick();
        chk_all("ign_idle2", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, S_IDLE);

        // ---- Rev_done saturation: 256 revolutions with Revs=0 ----
        Dir = 1'b1; Revs = 8'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 0; c < 8 * 256; c++) tick();
        chk_all("sat_wrap", 4'h0, 8'h01, 1'b1, 1'b1, 1'b0, 8'd255, S_RUN);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        chk_all("sat_stop", seq_right[1], 8'h02, 1'b0, 1'b1, 1'b0, 8'd255, S_STOP);
        for (int c = 0; c < 7; c++) tick();
        chk_all("sat_done", 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd255, S_DONE);
        tick();
        chk_all("sat_idle", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd255, S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
